// File: rtl/char_pixel_pipe.sv
// Text-mode pixel pipeline: char/attr fetch, glyph fetch, palette.
// Define CHARGEN_BLINK_EN for the bit-7 blink attribute.
module char_pixel_pipe #(
   parameter int CHAR_ADDR_W     = 12,
   parameter int FONT_ADDR_W     = 12,
   parameter int VGA_MAX_H_WIDTH = 10,
   parameter int VGA_MAX_V_WIDTH = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
   input  logic                       pixel_enable_i,
   input  logic                       vga_hs_i,
   input  logic                       vga_vs_i,
   output logic [CHAR_ADDR_W-1:0]     char_addr_o,
   input  logic [7:0]                 char_code_i,
   input  logic [7:0]                 color_i,
   output logic [FONT_ADDR_W-1:0]     font_addr_o,
   input  logic [7:0]                 font_row_i,
   output logic [3:0]                 vga_r_o,
   output logic [3:0]                 vga_g_o,
   output logic [3:0]                 vga_b_o,
   output logic                       vga_hs_o,
   output logic                       vga_vs_o
);

   typedef struct packed {
      logic [2:0] x;
      logic [3:0] y;
      logic       pe;
      logic       hs;
      logic       vs;
   } s1_t;

   typedef struct packed {
      logic [2:0] x;
      logic       pe;
      logic       hs;
      logic       vs;
   } s2_t;

   s1_t             s1_q;
   s2_t             s2_q;
   logic [7:0]      color_q;
   logic [11:0]     rgb_q;

   logic [6:0]             col;
   logic [4:0]             row;
   logic [CHAR_ADDR_W-1:0] cell_addr;
   logic                   glyph_bit;
   logic                   show_fg;
   logic [3:0]             fg;
   logic [3:0]             bg;
   logic [3:0]             idx;
   logic                   unused_hv;

   function automatic logic [11:0] palette(input logic [3:0] i);
      logic [3:0] lo;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      lo = i[3] ? 4'h5 : 4'h0;
      r  = (i[2] ? 4'hA : 4'h0) + lo;
      g  = (i[1] ? 4'hA : 4'h0) + lo;
      b  = (i[0] ? 4'hA : 4'h0) + lo;
      return {r, g, b};
   endfunction

   assign col       = hcount_i[9:3];
   assign row       = vcount_i[8:4];
   assign unused_hv = ^{hcount_i, vcount_i};

   // row*80 as row*64 + row*16
   assign cell_addr = CHAR_ADDR_W'({row, 6'b0})
                    + CHAR_ADDR_W'({row, 4'b0})
                    + CHAR_ADDR_W'(col);

   assign glyph_bit = font_row_i[3'd7 - s2_q.x];
   assign bg        = color_q[3:0];

`ifdef CHARGEN_BLINK_EN
   logic [4:0] frame_q;

   // Count frames on the falling edge of the delayed vsync
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_q <= '0;
      end else if (en_i && vga_vs_o && !s2_q.vs) begin
         frame_q <= frame_q + 5'd1;
      end
   end

   always_comb begin
      fg      = {1'b0, color_q[6:4]};
      show_fg = glyph_bit && !(color_q[7] && frame_q[4]);
   end
`else
   always_comb begin
      fg      = color_q[7:4];
      show_fg = glyph_bit;
   end
`endif

   assign idx = show_fg ? fg : bg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         char_addr_o <= '0;
         font_addr_o <= '0;
         s1_q        <= '{x: '0, y: '0, pe: 1'b0, hs: 1'b1, vs: 1'b1};
         s2_q        <= '{x: '0, pe: 1'b0, hs: 1'b1, vs: 1'b1};
         color_q     <= '0;
         rgb_q       <= '0;
         vga_hs_o    <= 1'b1;
         vga_vs_o    <= 1'b1;
      end else if (en_i) begin
         char_addr_o <= pixel_enable_i ? cell_addr : '0;
         s1_q.x      <= hcount_i[2:0];
         s1_q.y      <= vcount_i[3:0];
         s1_q.pe     <= pixel_enable_i;
         s1_q.hs     <= vga_hs_i;
         s1_q.vs     <= vga_vs_i;

         font_addr_o <= FONT_ADDR_W'({char_code_i, s1_q.y});
         color_q     <= color_i;
         s2_q.x      <= s1_q.x;
         s2_q.pe     <= s1_q.pe;
         s2_q.hs     <= s1_q.hs;
         s2_q.vs     <= s1_q.vs;

         rgb_q       <= s2_q.pe ? palette(idx) : 12'h000;
         vga_hs_o    <= s2_q.hs;
         vga_vs_o    <= s2_q.vs;
      end
   end

   assign vga_r_o = rgb_q[11:8];
   assign vga_g_o = rgb_q[7:4];
   assign vga_b_o = rgb_q[3:0];

endmodule

// File: tb/tb_char_pixel_pipe.sv
// Scoreboard bench for char_pixel_pipe with modelled sync memories.
// Blink expectations follow CHARGEN_BLINK_EN when defined.
module tb_char_pixel_pipe;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic [9:0]  hcount_i = '0;
   logic [9:0]  vcount_i = '0;
   logic        pixel_enable_i = 1'b0;
   logic        vga_hs_i = 1'b1;
   logic        vga_vs_i = 1'b1;
   logic [11:0] char_addr_o;
   logic [7:0]  char_code_i;
   logic [7:0]  color_i;
   logic [11:0] font_addr_o;
   logic [7:0]  font_row_i;
   logic [3:0]  vga_r_o;
   logic [3:0]  vga_g_o;
   logic [3:0]  vga_b_o;
   logic        vga_hs_o;
   logic        vga_vs_o;

`ifdef CHARGEN_BLINK_EN
   localparam logic [11:0] FG_F1      = 12'hAAA;
   localparam logic [11:0] BLINK_LATE = 12'h00A;
`else
   localparam logic [11:0] FG_F1      = 12'hFFF;
   localparam logic [11:0] BLINK_LATE = 12'hFFF;
`endif

   char_pixel_pipe dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .hcount_i       (hcount_i),
      .vcount_i       (vcount_i),
      .pixel_enable_i (pixel_enable_i),
      .vga_hs_i       (vga_hs_i),
      .vga_vs_i       (vga_vs_i),
      .char_addr_o    (char_addr_o),
      .char_code_i    (char_code_i),
      .color_i        (color_i),
      .font_addr_o    (font_addr_o),
      .font_row_i     (font_row_i),
      .vga_r_o        (vga_r_o),
      .vga_g_o        (vga_g_o),
      .vga_b_o        (vga_b_o),
      .vga_hs_o       (vga_hs_o),
      .vga_vs_o       (vga_vs_o)
   );

   always #5 clk = ~clk;

   logic [7:0] char_mem  [0:4095];
   logic [7:0] color_mem [0:4095];
   logic [7:0] font_mem  [0:4095];

   always @(posedge clk) begin
      char_code_i <= char_mem[char_addr_o];
      color_i     <= color_mem[char_addr_o];
      font_row_i  <= font_mem[font_addr_o];
   end

   typedef struct {
      int          due;
      logic [11:0] addr;
   } addr_e_t;

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } pix_e_t;

   addr_e_t addr_q[$];
   pix_e_t  pix_q[$];

   int vectors = 0;
   int miscompares = 0;
   int tick = 0;
   int stim_tick = 0;
   logic [11:0] last_rgb = 12'h000;
   logic        last_hs = 1'b1;
   logic        last_vs = 1'b1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin : monitor
      addr_e_t ae;
      pix_e_t  pe;
      if (en_i === 1'b1 && rst_i === 1'b0) begin
         tick++;
         #1;
         while (addr_q.size() > 0 && addr_q[0].due <= tick) begin
            ae = addr_q.pop_front();
            check("addr_timing", tick, ae.due);
            check("char_addr", {20'h0, char_addr_o}, {20'h0, ae.addr});
         end
         while (pix_q.size() > 0 && pix_q[0].due <= tick) begin
            pe = pix_q.pop_front();
            check("pix_timing", tick, pe.due);
            check("rgb", {20'h0, vga_r_o, vga_g_o, vga_b_o},
                  {20'h0, pe.rgb});
            check("hs_o", {31'h0, vga_hs_o}, {31'h0, pe.hs});
            check("vs_o", {31'h0, vga_vs_o}, {31'h0, pe.vs});
            last_rgb = pe.rgb;
            last_hs  = pe.hs;
            last_vs  = pe.vs;
         end
      end
   end

   task automatic issue(input int h, input int v, input logic pe,
                        input logic hs, input logic vs, input logic push,
                        input logic [11:0] ea, input logic [11:0] ergb);
      @(negedge clk);
      hcount_i       = h[9:0];
      vcount_i       = v[9:0];
      pixel_enable_i = pe;
      vga_hs_i       = hs;
      vga_vs_i       = vs;
      en_i           = 1'b1;
      stim_tick++;
      if (push) begin
         addr_q.push_back('{stim_tick, ea});
         pix_q.push_back('{stim_tick + 2, ergb, hs, vs});
      end
      @(negedge clk);
      en_i = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rgb"}, {20'h0, vga_r_o, vga_g_o, vga_b_o}, 32'h0);
      check({tag, "_hs"}, {31'h0, vga_hs_o}, 32'h1);
      check({tag, "_vs"}, {31'h0, vga_vs_o}, 32'h1);
      check({tag, "_caddr"}, {20'h0, char_addr_o}, 32'h0);
      check({tag, "_faddr"}, {20'h0, font_addr_o}, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         char_mem[i]  = 8'h00;
         color_mem[i] = 8'h00;
         font_mem[i]  = 8'h00;
      end
      char_mem[0]     = 8'h01; color_mem[0]    = 8'hF1;
      char_mem[81]    = 8'h03; color_mem[81]   = 8'h2E;
      char_mem[160]   = 8'h04; color_mem[160]  = 8'hF1;
      char_mem[2399]  = 8'h02; color_mem[2399] = 8'h3C;
      for (int y = 0; y < 16; y++) font_mem[12'h010 + y] = 8'hFF;
      font_mem[12'h02F] = 8'h01;
      font_mem[12'h030] = 8'h5A;
      font_mem[12'h040] = 8'h80;

      // reset with en toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en_i = ~en_i;
         @(posedge clk);
         #1;
         check_reset_state("reset");
      end
      @(negedge clk);
      rst_i = 1'b0;
      en_i  = 1'b0;

      // addressing: last cell and cell (1,1)
      issue(639, 479, 1'b1, 1'b1, 1'b1, 1'b1, 12'd2399, 12'h0AA);
      issue(8, 16, 1'b1, 1'b1, 1'b1, 1'b1, 12'd81, 12'hFF5);
      issue(9, 16, 1'b1, 1'b1, 1'b1, 1'b1, 12'd81, 12'h0A0);

      // blanking
      issue(5, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h000);
      issue(800, 520, 1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h000);

      // latency/alignment with hsync falling at h=3, stall after h=3
      for (int h = 0; h < 8; h++) begin
         issue(h, 32, 1'b1, (h < 3), 1'b1, 1'b1, 12'd160,
               (h == 0) ? FG_F1 : 12'h00A);
         if (h == 3) begin
            repeat (10) begin
               @(posedge clk);
               #1;
               check("stall_caddr", {20'h0, char_addr_o}, 32'd160);
               check("stall_faddr", {20'h0, font_addr_o}, 32'h040);
               check("stall_rgb", {20'h0, vga_r_o, vga_g_o, vga_b_o},
                     {20'h0, last_rgb});
               check("stall_hs", {31'h0, vga_hs_o}, {31'h0, last_hs});
            end
         end
      end
      repeat (3) issue(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h000);

      // mid-frame reset
      issue(0, 32, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'h000);
      issue(8, 16, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'h000);
      @(negedge clk);
      rst_i = 1'b1;
      en_i  = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst_i = 1'b0;
      en_i  = 1'b0;
      issue(9, 16, 1'b1, 1'b1, 1'b1, 1'b1, 12'd81, 12'h0A0);
      check("post_rst_rgb", {20'h0, vga_r_o, vga_g_o, vga_b_o}, 32'h0);
      repeat (2) issue(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h000);

      // blink: frame 0, then 16 vsync pulses
      issue(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, FG_F1);
      for (int f = 0; f < 16; f++) begin
         issue(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd0, 12'h000);
         issue(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd0, 12'h000);
      end
      issue(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, BLINK_LATE);
      repeat (2) issue(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 12'h000);

      repeat (4) @(negedge clk);
      check("drain", addr_q.size() + pix_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
